// File: rtl/pulse_train_gen.sv
// Pulse-train generator for a d2a control line: programmable delay, high width, low gap and count.
// Optional PULSE_TRAIN_GEN_ABORT_EN adds an abort input that cancels a running train.
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] init_delay,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] num_pulses,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             ctl,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] high_r, high_nxt, low_r, low_nxt;
    logic [NUM_W-1:0] num_r, num_nxt, idx_nxt;
    logic             ctl_nxt, busy_nxt, done_nxt;

    // Phase counters hold (width - 1); a programmed width of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] ld_val(input logic [CNT_W-1:0] w);
        return (w == '0) ? '0 : w - CNT_ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            high_r    <= '0;
            low_r     <= '0;
            num_r     <= '0;
            pulse_idx <= '0;
            ctl       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            high_r    <= high_nxt;
            low_r     <= low_nxt;
            num_r     <= num_nxt;
            pulse_idx <= idx_nxt;
            ctl       <= ctl_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        high_nxt  = high_r;
        low_nxt   = low_r;
        num_nxt   = num_r;
        idx_nxt   = pulse_idx;
        ctl_nxt   = ctl;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    high_nxt = high_cycles;
                    low_nxt  = low_cycles;
                    num_nxt  = num_pulses;
                    idx_nxt  = '0;
                    if (num_pulses == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        busy_nxt = 1'b1;
                        if (init_delay != '0) begin
                            state_nxt = DELAY;
                            cnt_nxt   = init_delay - CNT_ONE;
                            ctl_nxt   = 1'b0;
                        end else begin
                            state_nxt = HIGH;
                            cnt_nxt   = ld_val(high_cycles);
                            ctl_nxt   = 1'b1;
                        end
                    end
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    state_nxt = HIGH;
                    cnt_nxt   = ld_val(high_r);
                    ctl_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    ctl_nxt = 1'b0;
                    // Last pulse ends the train directly, without a trailing gap.
                    if (pulse_idx == num_r - NUM_ONE) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = LOW;
                        cnt_nxt   = ld_val(low_r);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    state_nxt = HIGH;
                    cnt_nxt   = ld_val(high_r);
                    ctl_nxt   = 1'b1;
                    idx_nxt   = pulse_idx + NUM_ONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef PULSE_TRAIN_GEN_ABORT_EN
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            ctl_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            idx_nxt   = pulse_idx;
        end
`endif
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: per-cycle ctl/busy/done checks against hand-computed patterns.
// The abort scenario is compiled in only with PULSE_TRAIN_GEN_ABORT_EN.
module tb_pulse_train_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] init_delay, high_cycles, low_cycles;
    logic [7:0]  num_pulses;
    logic        ctl, busy, done;
    logic [7:0]  pulse_idx;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    logic        abort;
`endif

    int checks = 0;
    int errors = 0;

    pulse_train_gen #(.CNT_W(16), .NUM_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_delay (init_delay),
        .high_cycles(high_cycles),
        .low_cycles (low_cycles),
        .num_pulses (num_pulses),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
        .abort      (abort),
`endif
        .ctl        (ctl),
        .busy       (busy),
        .done       (done),
        .pulse_idx  (pulse_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Starts a train and checks ctl/busy/done each cycle up to the done cycle (len).
    // disturb re-asserts start and changes config mid-train; the train must ignore it.
    task automatic run_train(input string name, input logic [15:0] d, input logic [15:0] h,
                             input logic [15:0] l, input logic [7:0] n,
                             input logic [63:0] exp_ctl, input int len, input bit disturb);
        init_delay  = d;
        high_cycles = h;
        low_cycles  = l;
        num_pulses  = n;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= len; c++) begin
            chk($sformatf("%s.ctl[%0d]", name, c), {31'b0, ctl}, {31'b0, exp_ctl[c]});
            chk($sformatf("%s.busy[%0d]", name, c), {31'b0, busy}, {31'b0, (c < len)});
            chk($sformatf("%s.done[%0d]", name, c), {31'b0, done}, {31'b0, (c == len)});
            if (disturb && c == 1) begin
                start       = 1'b1;
                init_delay  = 16'd3;
                high_cycles = 16'd7;
                low_cycles  = 16'd9;
                num_pulses  = 8'd9;
            end
            if (disturb && c == 2) start = 1'b0;
            if (c < len) tick();
        end
        tick();
        chk({name, ".done_clr"}, {31'b0, done}, 32'd0);
        chk({name, ".busy_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        init_delay  = '0;
        high_cycles = '0;
        low_cycles  = '0;
        num_pulses  = '0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
        abort       = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst.ctl", {31'b0, ctl}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.idx", {24'b0, pulse_idx}, 32'd0);

        // D=0 H=3 L=5 N=2: high 0-2, low 3-7, high 8-10, done at 11
        run_train("t1", 16'd0, 16'd3, 16'd5, 8'd2, 64'h707, 11, 1'b0);
        chk("t1.idx", {24'b0, pulse_idx}, 32'd1);

        // D=4 H=1 L=1 N=3: low 0-3, then 1,0,1,0,1 in 4-8, done at 9
        run_train("t2", 16'd4, 16'd1, 16'd1, 8'd3, 64'h150, 9, 1'b0);
        chk("t2.idx", {24'b0, pulse_idx}, 32'd2);

        // N=0: no pulse, no busy, done right after acceptance
        run_train("t3", 16'd5, 16'd3, 16'd3, 8'd0, 64'h0, 0, 1'b0);
        chk("t3.idx", {24'b0, pulse_idx}, 32'd0);

        // H=0 L=0 behave as 1; start and config changes mid-train are ignored
        run_train("t4", 16'd0, 16'd0, 16'd0, 8'd2, 64'h5, 3, 1'b1);
        chk("t4.idx", {24'b0, pulse_idx}, 32'd1);

        // Reset during second HIGH of an N=4 train (H=2 L=1: high 0,1 low 2 high 3,4)
        init_delay  = 16'd0;
        high_cycles = 16'd2;
        low_cycles  = 16'd1;
        num_pulses  = 8'd4;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("t5.ctl_pre", {31'b0, ctl}, 32'd1);
        chk("t5.idx_pre", {24'b0, pulse_idx}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5.ctl", {31'b0, ctl}, 32'd0);
        chk("t5.busy", {31'b0, busy}, 32'd0);
        chk("t5.done", {31'b0, done}, 32'd0);
        chk("t5.idx", {24'b0, pulse_idx}, 32'd0);
        tick();
        chk("t5.done_late", {31'b0, done}, 32'd0);
        chk("t5.ctl_late", {31'b0, ctl}, 32'd0);
        run_train("t6", 16'd0, 16'd2, 16'd1, 8'd4, 64'h6DB, 11, 1'b0);
        chk("t6.idx", {24'b0, pulse_idx}, 32'd3);

        // Start in the done cycle is accepted back-to-back
        init_delay  = 16'd0;
        high_cycles = 16'd1;
        low_cycles  = 16'd1;
        num_pulses  = 8'd1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("t7.ctl0", {31'b0, ctl}, 32'd1);
        tick();
        chk("t7.done1", {31'b0, done}, 32'd1);
        high_cycles = 16'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("t7.ctl2", {31'b0, ctl}, 32'd1);
        chk("t7.busy2", {31'b0, busy}, 32'd1);
        chk("t7.done2", {31'b0, done}, 32'd0);
        tick();
        chk("t7.ctl3", {31'b0, ctl}, 32'd1);
        tick();
        chk("t7.done4", {31'b0, done}, 32'd1);
        chk("t7.ctl4", {31'b0, ctl}, 32'd0);

`ifdef PULSE_TRAIN_GEN_ABORT_EN
        // D=0 H=2 L=3 N=3: pulse 1 high 5,6, low 7-9; abort in cycle 7
        tick();
        init_delay  = 16'd0;
        high_cycles = 16'd2;
        low_cycles  = 16'd3;
        num_pulses  = 8'd3;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        chk("ab.ctl_pre", {31'b0, ctl}, 32'd0);
        chk("ab.idx_pre", {24'b0, pulse_idx}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab.ctl", {31'b0, ctl}, 32'd0);
        chk("ab.busy", {31'b0, busy}, 32'd0);
        chk("ab.done", {31'b0, done}, 32'd1);
        chk("ab.idx", {24'b0, pulse_idx}, 32'd1);
        high_cycles = 16'd1;
        num_pulses  = 8'd1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("ab.ctl_new", {31'b0, ctl}, 32'd1);
        chk("ab.busy_new", {31'b0, busy}, 32'd1);
        chk("ab.done_new", {31'b0, done}, 32'd0);
        chk("ab.idx_new", {24'b0, pulse_idx}, 32'd0);
        tick();
        chk("ab.done_end", {31'b0, done}, 32'd1);
        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab.idle_done", {31'b0, done}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
